ins_writeback: RTL and testbench
================================

Name: ins_writeback

Overview:
- Commit stage downstream of the instruction executor; consumes its three write requests: register, memory store, PC redirect.
- Sequences each request into the register file, the data-memory write port and the PC register.
- Presents one retire event per instruction to the core sequencer.
- Buffers one request and waits on a ready/valid memory handshake with timeout.

Parameters:
MEM_TIMEOUT, 16, maximum cycles mem_req is held without mem_ready before abort (min 2)
PC_STEP, 4, sequential PC increment in bytes

Ports:
sys_clk  input  1  system clock, all state on rising edge
sys_rst  input  1  asynchronous active-high reset
wb_start  input  1  one-cycle pulse: request inputs valid this cycle
reg_w_op  input  1  register write requested
reg_w_reg_idx  input  5  destination register
reg_w_reg_val  input  32  destination value
mem_w_op  input  1  memory store requested
mem_w_mem_addr  input  32  store address
mem_w_mem_val  input  32  store data
reg_pc_w_op  input  1  PC redirect requested
reg_pc_w_val  input  32  redirect target
cur_pc  input  32  PC of the instruction being retired
mem_ready  input  1  memory accepts the store this cycle
wb_busy  output  1  request held; wb_start ignored
rf_w_en  output  1  register-file write strobe
rf_w_idx  output  5  register-file write index
rf_w_val  output  32  register-file write data
mem_req  output  1  store valid
mem_addr  output  32  store address
mem_wdata  output  32  store data
pc_w_en  output  1  PC write strobe
pc_w_val  output  32  next PC
wb_done  output  1  retire pulse
wb_err  output  1  store timed out, valid with wb_done
wb_trap  output  1  misaligned PC target, valid with wb_done

Behaviour:
- Reset (async, sys_rst=1):
  - All outputs 0; state IDLE; timeout counter 0; capture registers 0.
  - Reset mid-MEM drops mem_req immediately, with no retire.
- All outputs are registered.
- States: IDLE, MEM, RETIRE.
- IDLE:
  - wb_busy=0.
  - wb_start sampled 1 at edge k: capture all request inputs and cur_pc.
  - If mem_w_op=1, go to MEM; otherwise go to RETIRE.
- wb_start while not IDLE: ignored, nothing captured.
- MEM:
  - mem_req=1 with mem_addr/mem_wdata equal to the captured values, stable until accepted.
  - mem_ready sampled 1 at edge m: next state RETIRE; mem_req low after edge m.
  - Counter counts cycles spent in MEM. When it reaches MEM_TIMEOUT without mem_ready: drop mem_req, go to RETIRE, and set wb_err for the retire cycle.
  - mem_ready on the timeout edge: accepted, wb_err=0.
- RETIRE: exactly one cycle, then IDLE.
  - wb_done=1.
  - pc_w_en=1. pc_w_val = captured target if reg_pc_w_op, else cur_pc+PC_STEP mod 2^32 (wraps 0xFFFFFFFC -> 0x00000000).
  - rf_w_en=1 only if reg_w_op=1 and idx!=0; x0 writes are suppressed, but the retire still occurs.
  - rf_w_idx/rf_w_val hold the captured values in the retire cycle and are 0 otherwise.
- wb_busy=1 in MEM and RETIRE.
- Latency: no store -> wb_done in the cycle after edge k (1 cycle). Store -> the cycle after the accepting edge.
- Requests with all three ops 0 (e.g. nop): pc_w_val = cur_pc+PC_STEP; no rf write.
- One request in flight maximum; no queueing.

Optional Feature:
- Macro: INS_WRITEBACK_MISALIGN_TRAP_EN.
- Defined:
  - In RETIRE, if reg_pc_w_op=1 and target[1:0]!=0: wb_trap=1, pc_w_en=0, rf_w_en=0, wb_done=1.
  - An already-accepted store is not undone.
- Undefined: wb_trap tied 0; target written unchanged, including low bits.

Test Plan:
- Reset, then wb_start with reg_w_op=1, idx=5, val=0xDEADBEEF, cur_pc=0x100 -> next cycle rf_w_en=1 idx 5 val 0xDEADBEEF, pc_w_val=0x104, wb_done=1, one cycle only.
- Store addr 0x2000, data 0x12345678, mem_ready raised 3 cycles later -> mem_req held 3 cycles with stable addr/data; retire next cycle, pc_w_val=cur_pc+4, wb_err=0.
- Store with mem_ready never asserted, MEM_TIMEOUT=16 -> mem_req high 16 cycles then low; RETIRE with wb_err=1 and pc_w_en=1.
- JAL-style: reg_pc_w_op=1 target 0x400, reg_w_op=1 idx 1 val 0x104 -> pc_w_val=0x400, rf_w_en=1. Write to idx 0 instead -> rf_w_en=0, wb_done=1.
- cur_pc=0xFFFFFFFC, no redirect -> pc_w_val=0x00000000. Also: second wb_start during MEM is ignored, only one wb_done follows.
- sys_rst pulsed while mem_req=1 -> mem_req 0 asynchronously, no wb_done. With macro: target 0x402 -> wb_trap=1, pc_w_en=0.

Source files
------------

// File: rtl/ins_writeback.sv
// Commit stage: retires one instruction at a time into the register file, data memory and PC.
// Optional misaligned-redirect trap enabled by defining INS_WRITEBACK_MISALIGN_TRAP_EN.
module ins_writeback #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [31:0] PC_STEP     = 32'd4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        wb_start,
    input  logic        reg_w_op,
    input  logic [4:0]  reg_w_reg_idx,
    input  logic [31:0] reg_w_reg_val,
    input  logic        mem_w_op,
    input  logic [31:0] mem_w_mem_addr,
    input  logic [31:0] mem_w_mem_val,
    input  logic        reg_pc_w_op,
    input  logic [31:0] reg_pc_w_val,
    input  logic [31:0] cur_pc,
    input  logic        mem_ready,
    output logic        wb_busy,
    output logic        rf_w_en,
    output logic [4:0]  rf_w_idx,
    output logic [31:0] rf_w_val,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        pc_w_en,
    output logic [31:0] pc_w_val,
    output logic        wb_done,
    output logic        wb_err,
    output logic        wb_trap
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MEM    = 2'd1;
    localparam logic [1:0] S_RETIRE = 2'd2;

    localparam int unsigned       CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    // Captured request, used when the retire is reached through the store path
    logic        r_reg_op;
    logic [4:0]  r_reg_idx;
    logic [31:0] r_reg_val;
    logic        r_pc_op;
    logic [31:0] r_pc_tgt;
    logic [31:0] r_cur_pc;

    logic        r_busy;
    logic        r_rf_w_en;
    logic [4:0]  r_rf_w_idx;
    logic [31:0] r_rf_w_val;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_pc_w_en;
    logic [31:0] r_pc_w_val;
    logic        r_wb_done;
    logic        r_wb_err;
    logic        r_wb_trap;

    logic        w_in_idle;
    logic        w_accept;
    logic        w_timeout;
    logic        w_go_retire;
    logic        w_go_mem;
    logic        w_err_next;
    logic        w_src_reg_op;
    logic [4:0]  w_src_reg_idx;
    logic [31:0] w_src_reg_val;
    logic        w_src_pc_op;
    logic [31:0] w_src_pc_tgt;
    logic [31:0] w_src_cur_pc;
    logic [31:0] w_next_pc;
    logic        w_trap;
    logic        w_rf_en;

    assign w_in_idle = (r_state == S_IDLE);
    assign w_accept  = (r_state == S_MEM) && mem_ready;
    assign w_timeout = (r_state == S_MEM) && !mem_ready && (r_cnt == CNT_LAST);
    assign w_go_mem  = w_in_idle && wb_start && mem_w_op;

    // A retire is entered straight from IDLE (no store) or on leaving MEM
    assign w_go_retire = (w_in_idle && wb_start && !mem_w_op) || w_accept || w_timeout;
    assign w_err_next  = w_timeout;

    // Retire data comes from the live inputs on the IDLE path, else from the capture
    assign w_src_reg_op  = w_in_idle ? reg_w_op      : r_reg_op;
    assign w_src_reg_idx = w_in_idle ? reg_w_reg_idx : r_reg_idx;
    assign w_src_reg_val = w_in_idle ? reg_w_reg_val : r_reg_val;
    assign w_src_pc_op   = w_in_idle ? reg_pc_w_op   : r_pc_op;
    assign w_src_pc_tgt  = w_in_idle ? reg_pc_w_val  : r_pc_tgt;
    assign w_src_cur_pc  = w_in_idle ? cur_pc        : r_cur_pc;

    assign w_next_pc = w_src_pc_op ? w_src_pc_tgt : (w_src_cur_pc + PC_STEP);

`ifdef INS_WRITEBACK_MISALIGN_TRAP_EN
    assign w_trap = w_src_pc_op && (w_src_pc_tgt[1:0] != 2'b00);
`else
    assign w_trap = 1'b0;
`endif

    assign w_rf_en = w_src_reg_op && (w_src_reg_idx != 5'd0) && !w_trap;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_reg_op  <= 1'b0;
            r_reg_idx <= 5'd0;
            r_reg_val <= 32'd0;
            r_pc_op   <= 1'b0;
            r_pc_tgt  <= 32'd0;
            r_cur_pc  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wb_start) begin
                        r_reg_op  <= reg_w_op;
                        r_reg_idx <= reg_w_reg_idx;
                        r_reg_val <= reg_w_reg_val;
                        r_pc_op   <= reg_pc_w_op;
                        r_pc_tgt  <= reg_pc_w_val;
                        r_cur_pc  <= cur_pc;
                        r_cnt     <= '0;
                        r_state   <= mem_w_op ? S_MEM : S_RETIRE;
                    end
                end
                S_MEM: begin
                    if (w_accept || w_timeout) begin
                        r_state <= S_RETIRE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RETIRE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Store handshake outputs: asserted on entry to MEM, held until accept or timeout
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else if (w_go_mem) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= mem_w_mem_addr;
            r_mem_wdata <= mem_w_mem_val;
        end else if (w_accept || w_timeout) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_busy <= 1'b0;
        end else if (w_in_idle) begin
            r_busy <= wb_start;
        end else if (r_state == S_RETIRE) begin
            r_busy <= 1'b0;
        end
    end

    // Retire outputs live for exactly the one RETIRE cycle
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wb_done  <= 1'b0;
            r_wb_err   <= 1'b0;
            r_wb_trap  <= 1'b0;
            r_pc_w_en  <= 1'b0;
            r_pc_w_val <= 32'd0;
            r_rf_w_en  <= 1'b0;
            r_rf_w_idx <= 5'd0;
            r_rf_w_val <= 32'd0;
        end else if (w_go_retire) begin
            r_wb_done  <= 1'b1;
            r_wb_err   <= w_err_next;
            r_wb_trap  <= w_trap;
            r_pc_w_en  <= !w_trap;
            r_pc_w_val <= w_next_pc;
            r_rf_w_en  <= w_rf_en;
            r_rf_w_idx <= w_src_reg_idx;
            r_rf_w_val <= w_src_reg_val;
        end else begin
            r_wb_done  <= 1'b0;
            r_wb_err   <= 1'b0;
            r_wb_trap  <= 1'b0;
            r_pc_w_en  <= 1'b0;
            r_pc_w_val <= 32'd0;
            r_rf_w_en  <= 1'b0;
            r_rf_w_idx <= 5'd0;
            r_rf_w_val <= 32'd0;
        end
    end

    assign wb_busy   = r_busy;
    assign rf_w_en   = r_rf_w_en;
    assign rf_w_idx  = r_rf_w_idx;
    assign rf_w_val  = r_rf_w_val;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign pc_w_en   = r_pc_w_en;
    assign pc_w_val  = r_pc_w_val;
    assign wb_done   = r_wb_done;
    assign wb_err    = r_wb_err;
    assign wb_trap   = r_wb_trap;

endmodule

// File: tb/tb_ins_writeback.sv
// Directed-vector bench for ins_writeback; outputs sampled on the falling clock edge.
module tb_ins_writeback;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        wb_start;
    logic        reg_w_op;
    logic [4:0]  reg_w_reg_idx;
    logic [31:0] reg_w_reg_val;
    logic        mem_w_op;
    logic [31:0] mem_w_mem_addr;
    logic [31:0] mem_w_mem_val;
    logic        reg_pc_w_op;
    logic [31:0] reg_pc_w_val;
    logic [31:0] cur_pc;
    logic        mem_ready;
    logic        wb_busy;
    logic        rf_w_en;
    logic [4:0]  rf_w_idx;
    logic [31:0] rf_w_val;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        pc_w_en;
    logic [31:0] pc_w_val;
    logic        wb_done;
    logic        wb_err;
    logic        wb_trap;

    int vectors     = 0;
    int miscompares = 0;

    always #5 sys_clk = ~sys_clk;

    ins_writeback #(.MEM_TIMEOUT(16), .PC_STEP(32'd4)) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .wb_start       (wb_start),
        .reg_w_op       (reg_w_op),
        .reg_w_reg_idx  (reg_w_reg_idx),
        .reg_w_reg_val  (reg_w_reg_val),
        .mem_w_op       (mem_w_op),
        .mem_w_mem_addr (mem_w_mem_addr),
        .mem_w_mem_val  (mem_w_mem_val),
        .reg_pc_w_op    (reg_pc_w_op),
        .reg_pc_w_val   (reg_pc_w_val),
        .cur_pc         (cur_pc),
        .mem_ready      (mem_ready),
        .wb_busy        (wb_busy),
        .rf_w_en        (rf_w_en),
        .rf_w_idx       (rf_w_idx),
        .rf_w_val       (rf_w_val),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .pc_w_en        (pc_w_en),
        .pc_w_val       (pc_w_val),
        .wb_done        (wb_done),
        .wb_err         (wb_err),
        .wb_trap        (wb_trap)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic clear_inputs();
        wb_start       = 1'b0;
        reg_w_op       = 1'b0;
        reg_w_reg_idx  = 5'd0;
        reg_w_reg_val  = 32'd0;
        mem_w_op       = 1'b0;
        mem_w_mem_addr = 32'd0;
        mem_w_mem_val  = 32'd0;
        reg_pc_w_op    = 1'b0;
        reg_pc_w_val   = 32'd0;
        cur_pc         = 32'd0;
    endtask

    // Called at a falling edge; returns at the falling edge after the capturing edge
    task automatic start_req(input logic rop, input logic [4:0] idx, input logic [31:0] rval,
                             input logic mop, input logic [31:0] maddr, input logic [31:0] mval,
                             input logic pop, input logic [31:0] ptgt, input logic [31:0] cpc);
        wb_start       = 1'b1;
        reg_w_op       = rop;
        reg_w_reg_idx  = idx;
        reg_w_reg_val  = rval;
        mem_w_op       = mop;
        mem_w_mem_addr = maddr;
        mem_w_mem_val  = mval;
        reg_pc_w_op    = pop;
        reg_pc_w_val   = ptgt;
        cur_pc         = cpc;
        @(negedge sys_clk);
        clear_inputs();
    endtask

    task automatic check_idle(input string tag);
        @(negedge sys_clk);
        check_vec({tag, "_done_cleared"}, {31'd0, wb_done}, 32'd0);
        check_vec({tag, "_busy_cleared"}, {31'd0, wb_busy}, 32'd0);
    endtask

    initial begin
        int n;
        int dones;
        sys_rst   = 1'b1;
        mem_ready = 1'b0;
        clear_inputs();
        repeat (3) @(negedge sys_clk);
        check_vec("rst_busy",    {31'd0, wb_busy}, 32'd0);
        check_vec("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_vec("rst_done",    {31'd0, wb_done}, 32'd0);
        check_vec("rst_pc_w_en", {31'd0, pc_w_en}, 32'd0);
        check_vec("rst_rf_idx",  {27'd0, rf_w_idx}, 32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Register write, no store: retire one cycle after the start edge
        start_req(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'h100);
        check_vec("rw_rf_en",   {31'd0, rf_w_en}, 32'd1);
        check_vec("rw_rf_idx",  {27'd0, rf_w_idx}, 32'd5);
        check_vec("rw_rf_val",  rf_w_val, 32'hDEADBEEF);
        check_vec("rw_pc_en",   {31'd0, pc_w_en}, 32'd1);
        check_vec("rw_pc_val",  pc_w_val, 32'h104);
        check_vec("rw_done",    {31'd0, wb_done}, 32'd1);
        check_vec("rw_err",     {31'd0, wb_err}, 32'd0);
        check_vec("rw_busy",    {31'd0, wb_busy}, 32'd1);
        check_idle("rw");
        check_vec("rw_rf_en_cleared", {31'd0, rf_w_en}, 32'd0);

        // Store accepted after three cycles of mem_req
        start_req(1'b0, 5'd0, 32'd0, 1'b1, 32'h2000, 32'h12345678, 1'b0, 32'd0, 32'h200);
        for (int c = 1; c <= 3; c++) begin
            check_vec($sformatf("st_req_c%0d", c),  {31'd0, mem_req}, 32'd1);
            check_vec($sformatf("st_addr_c%0d", c), mem_addr, 32'h2000);
            check_vec($sformatf("st_data_c%0d", c), mem_wdata, 32'h12345678);
            check_vec($sformatf("st_done_c%0d", c), {31'd0, wb_done}, 32'd0);
            if (c == 3) mem_ready = 1'b1;
            @(negedge sys_clk);
        end
        mem_ready = 1'b0;
        check_vec("st_req_low", {31'd0, mem_req}, 32'd0);
        check_vec("st_done",    {31'd0, wb_done}, 32'd1);
        check_vec("st_pc_val",  pc_w_val, 32'h204);
        check_vec("st_err",     {31'd0, wb_err}, 32'd0);
        check_vec("st_rf_en",   {31'd0, rf_w_en}, 32'd0);
        check_idle("st");

        // Store never accepted; a second wb_start mid-MEM must be ignored
        start_req(1'b0, 5'd0, 32'd0, 1'b1, 32'h3000, 32'hCAFEF00D, 1'b0, 32'd0, 32'h300);
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            if (n == 5) begin
                wb_start      = 1'b1;
                reg_w_op      = 1'b1;
                reg_w_reg_idx = 5'd7;
                reg_w_reg_val = 32'h77;
                cur_pc        = 32'h900;
            end
            @(negedge sys_clk);
            clear_inputs();
        end
        check_vec("to_req_cycles", n, 32'd16);
        check_vec("to_done",   {31'd0, wb_done}, 32'd1);
        check_vec("to_err",    {31'd0, wb_err}, 32'd1);
        check_vec("to_pc_en",  {31'd0, pc_w_en}, 32'd1);
        check_vec("to_pc_val", pc_w_val, 32'h304);
        check_vec("to_rf_en",  {31'd0, rf_w_en}, 32'd0);
        dones = 0;
        repeat (5) begin
            @(negedge sys_clk);
            if (wb_done === 1'b1) dones++;
        end
        check_vec("to_extra_done", dones, 32'd0);
        check_vec("to_idle_busy", {31'd0, wb_busy}, 32'd0);

        // mem_ready arriving on the timeout edge counts as accepted
        start_req(1'b0, 5'd0, 32'd0, 1'b1, 32'h4000, 32'h1, 1'b0, 32'd0, 32'h400);
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            if (n == 16) mem_ready = 1'b1;
            @(negedge sys_clk);
        end
        mem_ready = 1'b0;
        check_vec("tedge_cycles", n, 32'd16);
        check_vec("tedge_done",   {31'd0, wb_done}, 32'd1);
        check_vec("tedge_err",    {31'd0, wb_err}, 32'd0);
        check_idle("tedge");

        // JAL-style: redirect plus link register write
        start_req(1'b1, 5'd1, 32'h104, 1'b0, 32'd0, 32'd0, 1'b1, 32'h400, 32'h100);
        check_vec("jal_pc_val", pc_w_val, 32'h400);
        check_vec("jal_rf_en",  {31'd0, rf_w_en}, 32'd1);
        check_vec("jal_rf_idx", {27'd0, rf_w_idx}, 32'd1);
        check_vec("jal_rf_val", rf_w_val, 32'h104);
        check_idle("jal");

        // Link to x0: write suppressed, retire still happens
        start_req(1'b1, 5'd0, 32'h104, 1'b0, 32'd0, 32'd0, 1'b1, 32'h400, 32'h100);
        check_vec("x0_rf_en",  {31'd0, rf_w_en}, 32'd0);
        check_vec("x0_done",   {31'd0, wb_done}, 32'd1);
        check_vec("x0_pc_en",  {31'd0, pc_w_en}, 32'd1);
        check_vec("x0_pc_val", pc_w_val, 32'h400);
        check_idle("x0");

        // Nop at the top of the address space wraps the PC
        start_req(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'hFFFFFFFC);
        check_vec("wrap_pc_val", pc_w_val, 32'h0);
        check_vec("wrap_pc_en",  {31'd0, pc_w_en}, 32'd1);
        check_vec("wrap_rf_en",  {31'd0, rf_w_en}, 32'd0);
        check_vec("wrap_done",   {31'd0, wb_done}, 32'd1);
        check_idle("wrap");

        // Misaligned redirect target
        start_req(1'b1, 5'd3, 32'h55, 1'b0, 32'd0, 32'd0, 1'b1, 32'h402, 32'h100);
        check_vec("mis_done", {31'd0, wb_done}, 32'd1);
`ifdef INS_WRITEBACK_MISALIGN_TRAP_EN
        check_vec("mis_trap",  {31'd0, wb_trap}, 32'd1);
        check_vec("mis_pc_en", {31'd0, pc_w_en}, 32'd0);
        check_vec("mis_rf_en", {31'd0, rf_w_en}, 32'd0);
`else
        check_vec("mis_trap",   {31'd0, wb_trap}, 32'd0);
        check_vec("mis_pc_en",  {31'd0, pc_w_en}, 32'd1);
        check_vec("mis_pc_val", pc_w_val, 32'h402);
        check_vec("mis_rf_en",  {31'd0, rf_w_en}, 32'd1);
`endif
        check_idle("mis");

        // Asynchronous reset in the middle of a store
        start_req(1'b1, 5'd9, 32'h99, 1'b1, 32'h5000, 32'h5, 1'b0, 32'd0, 32'h500);
        @(negedge sys_clk);
        check_vec("arst_req_before", {31'd0, mem_req}, 32'd1);
        #2 sys_rst = 1'b1;
        #1;
        check_vec("arst_req_after",  {31'd0, mem_req}, 32'd0);
        check_vec("arst_busy_after", {31'd0, wb_busy}, 32'd0);
        check_vec("arst_addr_after", mem_addr, 32'd0);
        @(negedge sys_clk);
        sys_rst   = 1'b0;
        mem_ready = 1'b1;
        dones = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (wb_done === 1'b1) dones++;
        end
        mem_ready = 1'b0;
        check_vec("arst_no_done", dones, 32'd0);
        check_vec("arst_no_req",  {31'd0, mem_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
